sub32f_stream: RTL and testbench
================================

// Module: sub32f_stream
// PURPOSE
//  Streaming front-end/back-end around the combinational Sub32F core (op1, op2 -> diff).
//  Buffers operand pairs in a FIFO with a valid/ready input side.
//  Presents the FIFO head to Sub32F and registers diff into a valid/ready output slot.
//  Sits between the operand producer and the result consumer; sustains one subtraction per cycle.
// PARAMETERS
//  DEPTH  4  operand FIFO entries; power of 2, >= 2
//  AW     2  pointer width, = log2(DEPTH)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   operand pair offered
//  in_ready   out  1   FIFO can accept (combinational: count != DEPTH)
//  in_op1     in   32  IEEE-754 single minuend
//  in_op2     in   32  IEEE-754 single subtrahend
//  out_valid  out  1   out_diff holds a result
//  out_ready  in   1   consumer takes result this cycle
//  out_diff   out  32  registered Sub32F diff of FIFO head pair
//  out_flags  out  2   {nan, inf} of out_diff (SUB32F_STREAM_EXC_EN only)
// BEHAVIOUR
//  - Reset: one clock, clk; reset is asynchronous and active-high on rst.
//    rst clears wr_ptr, rd_ptr, count, out_valid and out_diff (0), and out_flags (0 when present).
//    in_ready is 1 during and after reset. FIFO storage is not cleared.
//  - Push: in_valid && in_ready at the edge writes {in_op1,in_op2} at wr_ptr; wr_ptr+1 mod DEPTH.
//  - Pop/load: when count!=0 && (!out_valid || out_ready) at the edge:
//    - out_diff <= Sub32F(head) and out_valid <= 1; rd_ptr+1 mod DEPTH.
//  - Drain: when out_valid && out_ready && count==0, out_valid <= 0; out_diff keeps its last value.
//  - Stall: when out_valid && !out_ready, out_diff and out_valid hold.
//  - count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
//    Range 0..DEPTH; pointers wrap silently.
//  - Full: in_ready=0. No write-through bypass, so a push is refused even if a pop occurs in the same cycle.
//  - Empty: Sub32F sees the stale head; its result is ignored (no load).
//  - Latency: a pair accepted at edge N appears with out_valid=1 after edge N+1, given the FIFO was empty
//    and the output slot was free. Throughput: 1 pair/cycle with out_ready held at 1.
//  - Capacity under full backpressure: DEPTH+1 pairs (DEPTH in FIFO + 1 in output slot).
//  - Ordering: strict FIFO; no drops, no duplicates.
//  - Reset mid-operation: all buffered pairs are discarded.
//    out_valid falls asynchronously with rst; no result leaks out after reset.
//  - Arithmetic: entirely inside one Sub32F instance; this block adds no rounding or width changes.
// CONFIGURATION
//  SUB32F_STREAM_EXC_EN defined:
//    - out_flags is registered together with out_diff and held/stalled identically.
//    - nan = (exp==8'hFF && man!=0); inf = (exp==8'hFF && man==0).
//  SUB32F_STREAM_EXC_EN undefined: the out_flags port does not exist; all other behaviour is identical.
// TESTING
//  1 Reset, idle: rst=1 -> out_valid=0, out_diff=0, in_ready=1; release -> unchanged.
//  2 Single op: push 40400000,3F800000 with out_ready=1 -> out_valid=1 two edges later, out_diff=40000000;
//    push 3F800000,3F800000 -> 00000000.
//  3 Backpressure (DEPTH=4): out_ready=0, offer 6 pairs -> 5 accepted, in_ready=0 after the 5th;
//    raise out_ready -> 5 results in push order, one per cycle.
//  4 Streaming: in_valid=1 and out_ready=1 for 20 cycles with random pairs -> one result per cycle,
//    each matching the C model in data.tb; count stays <= 1.
//  5 Reset mid-op: fill 3 pairs, assert rst for 1 cycle -> out_valid=0 immediately, in_ready=1,
//    no stale results afterwards.
//  6 Flags (EXC_EN): 7F800000-7F800000 -> out_flags=2'b10;
//    7F800000-3F800000 -> out_diff=7F800000, out_flags=2'b01.

Source files
------------

// File: rtl/sub32f_stream.sv
// sub32f_stream: operand FIFO -> combinational Sub32F -> registered result slot.
// Optional feature macro: SUB32F_STREAM_EXC_EN adds the registered out_flags {nan, inf} port.
// Sub32F computes op1 - op2 in IEEE-754 single precision, round-to-nearest-even,
// with subnormal operands/results; any NaN result is the canonical quiet NaN 7FC00000.

module sub32f (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] diff
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        a_s, b_s, l_s, eff_sub, swap, found;
  logic        a_nan, b_nan, a_inf, b_inf, rnd;
  logic [7:0]  a_e, b_e, l_e, s_e, d;
  logic [23:0] l_m, s_m;
  logic [4:0]  dc, lz, sh;
  logic [53:0] wide;
  logic [26:0] aligned, norm;
  logic [27:0] sum;
  logic [8:0]  e_n;
  logic [7:0]  e_f;
  logic [31:0] res;

  // Align, add/subtract magnitudes, normalise (clamped at the subnormal boundary), round.
  always_comb begin
    a_s   = op1[31];
    b_s   = ~op2[31];  // subtraction as addition of the negated subtrahend
    a_e   = op1[30:23];
    b_e   = op2[30:23];
    a_nan = (a_e == 8'hFF) && (op1[22:0] != 23'd0);
    b_nan = (b_e == 8'hFF) && (op2[22:0] != 23'd0);
    a_inf = (a_e == 8'hFF) && (op1[22:0] == 23'd0);
    b_inf = (b_e == 8'hFF) && (op2[22:0] == 23'd0);
    eff_sub = a_s ^ b_s;
    // Order by magnitude so the large operand never goes negative.
    swap = op2[30:0] > op1[30:0];
    l_s  = swap ? b_s : a_s;
    l_e  = swap ? b_e : a_e;
    s_e  = swap ? a_e : b_e;
    l_m  = swap ? {(b_e != 8'd0), op2[22:0]} : {(a_e != 8'd0), op1[22:0]};
    s_m  = swap ? {(a_e != 8'd0), op1[22:0]} : {(b_e != 8'd0), op2[22:0]};
    // Subnormals use exponent 1 with a zero hidden bit.
    if (l_e == 8'd0) l_e = 8'd1;
    if (s_e == 8'd0) s_e = 8'd1;
    d  = l_e - s_e;
    dc = (d > 8'd31) ? 5'd31 : d[4:0];
    // 27-bit working mantissa: 24 significant bits plus guard, round, sticky.
    wide    = {s_m, 3'b000, 27'd0} >> dc;
    aligned = wide[53:27] | {26'd0, |wide[26:0]};
    sum = eff_sub ? ({1'b0, l_m, 3'b000} - {1'b0, aligned})
                  : ({1'b0, l_m, 3'b000} + {1'b0, aligned});
    lz    = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    sh = 5'd0;
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e_n  = {1'b0, l_e} + 9'd1;
    end else begin
      // Never shift below exponent 1; whatever is left becomes a subnormal.
      sh   = ({3'd0, lz} > (l_e - 8'd1)) ? 5'(l_e - 8'd1) : lz;
      norm = sum[26:0] << sh;
      e_n  = {1'b0, l_e} - {4'd0, sh};
    end
    e_f = norm[26] ? e_n[7:0] : 8'd0;
    rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
    // Mantissa carry ripples into the exponent: subnormal->normal and overflow->inf both fall out.
    res = {1'b0, e_f, norm[25:3]} + {31'd0, rnd};

    if (a_nan || b_nan)       diff = QNAN;
    else if (a_inf && b_inf)  diff = eff_sub ? QNAN : {a_s, 8'hFF, 23'd0};
    else if (a_inf)           diff = {a_s, 8'hFF, 23'd0};
    else if (b_inf)           diff = {b_s, 8'hFF, 23'd0};
    else if (sum == 28'd0)    diff = {(eff_sub ? 1'b0 : l_s), 31'd0};
    else if (e_n >= 9'd255 || res[30:23] == 8'hFF) diff = {l_s, 8'hFF, 23'd0};
    else                      diff = {l_s, res[30:0]};
  end
endmodule

module sub32f_stream #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_diff
`ifdef SUB32F_STREAM_EXC_EN
  ,
  output logic [1:0]  out_flags
`endif
);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_diff_q, out_diff_d, diff_w;
  logic          push, pop;
  logic [63:0]   head;

  assign head     = mem[rd_ptr_q];
  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && (!out_valid_q || out_ready);

  sub32f u_sub (
    .op1  (head[63:32]),
    .op2  (head[31:0]),
    .diff (diff_w)
  );

  // Operand storage; never reset, contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_op1, in_op2};
  end

  // Next-state for pointers, occupancy and the output slot.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_diff_d  = out_diff_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (pop) begin
      out_valid_d = 1'b1;
      out_diff_d  = diff_w;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;  // drained; last diff stays visible
    end
  end

  // Control and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_diff_q  <= out_diff_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_diff  = out_diff_q;

`ifdef SUB32F_STREAM_EXC_EN
  logic [1:0] flags_q, flags_d;

  // Exception flags follow the result slot exactly, including stalls.
  always_comb begin
    flags_d = flags_q;
    if (pop) flags_d = {(diff_w[30:23] == 8'hFF) && (diff_w[22:0] != 23'd0),
                        (diff_w[30:23] == 8'hFF) && (diff_w[22:0] == 23'd0)};
  end

  // Flag register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 2'b00;
    else     flags_q <= flags_d;
  end

  assign out_flags = flags_q;
`endif
endmodule

// File: tb/tb_sub32f_stream.sv
// Randomised scoreboard bench for sub32f_stream; reference is real-number subtraction.
// Build with +define+SUB32F_STREAM_EXC_EN to also exercise out_flags.
`timescale 1ns/1ps
module tb_sub32f_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_op1 = '0, in_op2 = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_diff;
`ifdef SUB32F_STREAM_EXC_EN
  logic [1:0]  out_flags;
`endif

  int checks = 0, failures = 0, accepted = 0;
  logic [31:0] exp_q[$];

  sub32f_stream #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .out_valid(out_valid),
    .out_ready(out_ready), .out_diff(out_diff)
`ifdef SUB32F_STREAM_EXC_EN
    , .out_flags(out_flags)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Single float <-> double for normal numbers and zero.
  function automatic logic [63:0] f2d(input logic [31:0] f);
    if (f[30:0] == 31'd0) return {f[31], 63'd0};
    return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [7:0]  e;
    logic [28:0] rest;
    logic        up;
    if (d[62:0] == 63'd0) return 32'd0;
    e    = 8'(d[62:52] - 11'd896);
    rest = d[28:0];
    up   = (rest > 29'h1000_0000) || (rest == 29'h1000_0000 && d[29]);
    return {d[63], e, d[51:29]} + {31'd0, up};
  endfunction

  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic an, bn, ai, bi;
    real  r;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (an || bn) return 32'h7FC0_0000;
    if (ai && bi) return (a[31] == b[31]) ? 32'h7FC0_0000 : a;
    if (ai) return a;
    if (bi) return {~b[31], b[30:0]};
    r = $bitstoreal(f2d(a)) - $bitstoreal(f2d(b));
    return d2f($realtobits(r));
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
  endfunction

  task automatic rnd_pair(output logic [31:0] a, output logic [31:0] b);
    a = rnd_f();
    if ($urandom_range(3, 0) == 0)
      b = {1'($urandom), a[30:0] ^ {23'd0, 8'($urandom_range(255, 0))}};
    else
      b = rnd_f();
  endtask

  // Input-side tracker: every accepted pair enqueues its expected result.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(ref_sub(in_op1, in_op2));
      accepted++;
    end
  end

  // Output-side monitor: compares each handshake and every stalled cycle against the head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk(out_ready ? "result" : "stall_hold", out_diff, exp_q[0]);
`ifdef SUB32F_STREAM_EXC_EN
        chk("result_flags", {30'd0, out_flags},
            {30'd0, (exp_q[0][30:23] == 8'hFF) && (exp_q[0][22:0] != 0),
                    (exp_q[0][30:23] == 8'hFF) && (exp_q[0][22:0] == 0)});
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_one(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op1 = a; in_op2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk(name, {31'd0, out_valid}, 32'd1);
  endtask

  logic [31:0] a, b;

  initial begin
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_diff", out_diff, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Single operations and latency
    out_ready = 1'b1;
    push_one(32'h4040_0000, 32'h3F80_0000);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("three_minus_one", out_diff, 32'h4000_0000);
    push_one(32'h3F80_0000, 32'h3F80_0000);
    wait_valid("one_minus_one_valid");
    chk("one_minus_one", out_diff, 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: capacity DEPTH+1
    out_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      rnd_pair(a, b);
      in_valid = 1'b1; in_op1 = a; in_op2 = b;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(accepted), 32'd5);
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Streaming, one pair per cycle
    for (int i = 0; i < 20; i++) begin
      rnd_pair(a, b);
      in_valid = 1'b1; in_op1 = a; in_op2 = b;
      @(posedge clk); #1;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of operation
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rnd_pair(a, b);
      push_one(a, b);
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_diff", out_diff, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);
    end
    push_one(32'h4120_0000, 32'h3F80_0000);
    wait_valid("post_rst_recover_valid");
    chk("ten_minus_one", out_diff, 32'h4110_0000);
    @(posedge clk); #1;

`ifdef SUB32F_STREAM_EXC_EN
    // Exception flags
    push_one(32'h7F80_0000, 32'h7F80_0000);
    wait_valid("inf_minus_inf_valid");
    chk("inf_minus_inf_flags", {30'd0, out_flags}, 32'd2);
    @(posedge clk); #1;
    push_one(32'h7F80_0000, 32'h3F80_0000);
    wait_valid("inf_minus_one_valid");
    chk("inf_minus_one", out_diff, 32'h7F80_0000);
    chk("inf_minus_one_flags", {30'd0, out_flags}, 32'd1);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
